inst_fetch_q: RTL



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 98 +++++++++
 rtl/inst_fetch_q.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN_DEF      : default address/PC width
//   INST_W        : instruction width
//   PC_STEP       : sequential PC increment in bytes
//   fetch_entry_t : one fetch-queue slot {pc, inst, filled} at the default width
package fetch_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned PC_STEP  = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INST_W-1:0]   inst;
    logic                filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue with three pointers.
//   alloc : reserves a slot for an issued request and records its PC
//   fill  : writes the returned instruction into the oldest unfilled slot
//   head  : presents the oldest slot to decode; pop frees it
//   flush : frees every slot (pointers collapse onto alloc)
// Ports: clk, rst (async high), flush, alloc_en/alloc_pc, fill_en/fill_inst,
//        pop_en, head_filled/head_pc/head_inst, used (allocated slots),
//        unfilled (allocated slots still waiting for memory).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_en,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              fill_en,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              pop_en,
  output logic              head_filled,
  output logic [XLEN-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic [CNT_W-1:0]  used,
  output logic [CNT_W-1:0]  unfilled
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CNT_W-1:0]  alloc_ptr;
  logic [CNT_W-1:0]  fill_ptr;
  logic [CNT_W-1:0]  head_ptr;
  logic [XLEN-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  filled;

  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] head_idx;

  assign alloc_idx = alloc_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign head_idx  = head_ptr[AW-1:0];

  assign used        = alloc_ptr - head_ptr;
  assign unfilled    = alloc_ptr - fill_ptr;
  assign head_filled = filled[head_idx];
  assign head_pc     = pc_q[head_idx];
  assign head_inst   = inst_q[head_idx];

  // Slot state. A fill into the slot being allocated in the same cycle
  // (zero-latency memory) is written after the alloc so filled ends up set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      filled    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= alloc_ptr;
      fill_ptr <= alloc_ptr;
      filled   <= '0;
    end else begin
      if (pop_en) begin
        filled[head_idx] <= 1'b0;
        head_ptr         <= head_ptr + CNT_W'(1);
      end
      if (alloc_en) begin
        pc_q[alloc_idx]   <= alloc_pc;
        filled[alloc_idx] <= 1'b0;
        alloc_ptr         <= alloc_ptr + CNT_W'(1);
      end
      if (fill_en) begin
        inst_q[fill_idx] <= fill_inst;
        filled[fill_idx] <= 1'b1;
        fill_ptr         <= fill_ptr + CNT_W'(1);
      end
    end
  end

  // Occupancy never exceeds the slot count; fills only target allocated slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (used <= CNT_W'(DEPTH));
      assert (unfilled <= used);
      assert (!(fill_en && !flush && !alloc_en && (unfilled == '0)));
    end
  end

endmodule

// File: rtl/inst_fetch_q.sv
// Decoupled instruction-fetch stage: PC register, request issue, stale
// response drop counter and a DEPTH-entry fetch queue feeding decode.
// Ports:
//   clk, rst                       clock, async active-high reset
//   redirect_valid, redirect_pc    branch/jump redirect (pc[1:0] ignored)
//   imem_req_valid/ready/addr      in-order fetch request channel
//   imem_rsp_valid/data            in-order response, no backpressure
//   out_valid/ready/inst/pc        instruction handshake to decode
module inst_fetch_q
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("inst_fetch_q: DEPTH must be a power of two >= 2");
  end

  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_nxt;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] unfilled;
  logic [SUM_W-1:0] budget;
  logic             head_filled;
  logic             req_fire;
  logic             fill_en;
  logic             out_fire;

  // Slots are charged for allocated entries plus responses still owed to
  // requests that a redirect already discarded.
  assign budget = SUM_W'(used) + SUM_W'(drop_cnt);

  // Handshake qualification; redirect blocks issue, fill and output fire.
  always_comb begin
    imem_req_valid = !rst && !redirect_valid && (budget < SUM_W'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    fill_en        = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    out_valid      = head_filled && !redirect_valid;
    out_fire       = out_valid && out_ready;
  end

  assign imem_req_addr = pc;

  // On redirect every unfilled slot becomes an owed response. A response in
  // the redirect cycle is consumed either way: it would have filled one of
  // those slots, or it retires one already-owed response.
  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_valid) begin
      drop_nxt = drop_cnt + unfilled - CNT_W'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_nxt = drop_cnt - CNT_W'(1);
    end
  end

  // PC and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      if (redirect_valid) begin
        pc <= redirect_pc & ~XLEN'(3);
      end else if (req_fire) begin
        pc <= pc + XLEN'(PC_STEP);
      end
    end
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .alloc_en    (req_fire),
    .alloc_pc    (pc),
    .fill_en     (fill_en),
    .fill_inst   (imem_rsp_data),
    .pop_en      (out_fire),
    .head_filled (head_filled),
    .head_pc     (out_pc),
    .head_inst   (out_inst),
    .used        (used),
    .unfilled    (unfilled)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (drop_cnt <= CNT_W'(DEPTH));
      assert (budget <= SUM_W'(DEPTH));
    end
  end

endmodule
